// File: rtl/is_pkg_uart_controller.sv
// Shared types and helpers for the UART controller datapaths.
// The TX_PARITY state exists only when UART_TX_PARITY_EN is defined.
package is_pkg_uart_controller;

    localparam int DATA_W = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;
`endif

    function automatic int clks_per_bit(input int clk_freq,
                                        input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/is_baud_tick.sv
// Modulo-CLKS_PER_BIT baud counter with enable and synchronous clear.
// bit_end_o is high in the last cycle of each bit period.
module is_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_end_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= bit_end_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/is_uart_tx.sv
// UART transmit serializer: start, 8 data bits LSB first, stop bit(s).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module is_uart_tx
    import is_pkg_uart_controller::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              tx_valid_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              tx_ack_o,
    output logic              busy_o,
    output logic              txd_o
);

    localparam int   CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic LAST_STOP    = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("is_uart_tx: CLK_FREQ / BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("is_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("is_uart_tx: PARITY_ODD must be 0 or 1");
    end

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [2:0]        bit_cnt_q;
    logic              stop_cnt_q;
    logic              bit_end;
    logic              last_stop;
    logic              capture;
    logic              txd_d;
    logic              busy_d;

    // busy_o gates the counter so the start bit begins exactly at capture
    is_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (busy_o),
        .clr_i    (capture),
        .bit_end_o(bit_end)
    );

    assign last_stop = (state_q == TX_STOP) && bit_end &&
                       (stop_cnt_q == LAST_STOP);
    assign capture   = tx_valid_i &&
                       ((state_q == TX_IDLE) || last_stop);

`ifdef UART_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            par_q <= 1'b0;
        end else if (capture) begin
            par_q <= (^tx_data_i) ^ 1'(PARITY_ODD);
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= TX_IDLE;
            txd_o    <= 1'b1;
            busy_o   <= 1'b0;
            tx_ack_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            txd_o    <= txd_d;
            busy_o   <= busy_d;
            tx_ack_o <= capture;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:  if (capture) state_d = TX_START;
            TX_START: if (bit_end) state_d = TX_DATA;
`ifdef UART_TX_PARITY_EN
            TX_DATA:  if (bit_end && bit_cnt_q == 3'd7)
                          state_d = TX_PARITY;
            TX_PARITY: if (bit_end) state_d = TX_STOP;
`else
            TX_DATA:  if (bit_end && bit_cnt_q == 3'd7)
                          state_d = TX_STOP;
`endif
            TX_STOP:  if (last_stop)
                          state_d = capture ? TX_START : TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Outputs are decoded from next state so they register in step with it
    always_comb begin
        shift_d = shift_q;
        if (capture) begin
            shift_d = tx_data_i;
        end else if (state_q == TX_DATA && bit_end) begin
            shift_d = shift_q >> 1;
        end
        busy_d = (state_d != TX_IDLE);
        txd_d  = 1'b1;
        unique case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY: txd_d = par_q;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            if (capture) begin
                bit_cnt_q  <= '0;
                stop_cnt_q <= 1'b0;
            end else if (bit_end) begin
                if (state_q == TX_DATA) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (state_q == TX_STOP) begin
                    stop_cnt_q <= last_stop ? 1'b0 : ~stop_cnt_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_is_uart_tx.sv
// Scoreboard bench for is_uart_tx at 16 clocks per bit.
// Follows UART_TX_PARITY_EN so it checks whichever build is compiled.
module tb_is_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 10 + P;
    localparam int F  = NB * CPB;
    localparam int F2 = (NB + 1) * CPB;

    logic       clk_i = 1'b0;
    logic       rstn_i = 1'b0;
    logic       tx_valid_i = 1'b0;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_ack_o, busy_o, txd_o;
    logic       v2 = 1'b0;
    logic [7:0] d2 = 8'h00;
    logic       ack2, busy2, txd2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ack_n = 0;
    int exp_acks = 0;
    logic [7:0] exp_q[$];

    is_uart_tx #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000),
        .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i),
        .tx_ack_o(tx_ack_o), .busy_o(busy_o), .txd_o(txd_o)
    );

    is_uart_tx #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000),
        .STOP_BITS(2), .PARITY_ODD(0)
    ) dut2 (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .tx_valid_i(v2), .tx_data_i(d2),
        .tx_ack_o(ack2), .busy_o(busy2), .txd_o(txd2)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (tx_ack_o === 1'b1) ack_n <= ack_n + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [11:0] frame_of(input logic [7:0] b);
        logic [11:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    task automatic send(input logic [7:0] b, input bit hold,
                        output int at);
        int n;
        n = 0;
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            n++;
        end while (tx_ack_o !== 1'b1 && n < 4 * F);
        check("ack_seen", tx_ack_o, 1);
        at = cyc;
        if (tx_ack_o === 1'b1) begin
            exp_q.push_back(b);
            exp_acks++;
        end
        if (!hold) tx_valid_i = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy_o === 1'b1 && n < 4 * F) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    // Line monitor: one frame per start bit, each bit must hold 16 cycles
    initial begin : monitor
        logic [11:0] obs;
        logic [7:0]  e;
        int          glitch;
        bit          abort;
        forever begin
            @(negedge clk_i);
            if (rstn_i === 1'b1 && txd_o === 1'b0) begin
                obs = '1;
                glitch = 0;
                abort = 0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk_i);
                        if (rstn_i !== 1'b1) begin
                            abort = 1;
                            break;
                        end
                        if (c == 0) obs[b] = txd_o;
                        else if (txd_o !== obs[b]) glitch++;
                    end
                    if (abort) break;
                end
                if (abort) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", 32'(obs), 32'(frame_of(e)));
                    check("bit_stable", glitch, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a1, a2, n, lo, hi;

        repeat (3) @(negedge clk_i);
        check("rst_txd", txd_o, 1);
        check("rst_ack", tx_ack_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_txd2", txd2, 1);
        rstn_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("idle_txd", txd_o, 1);
        check("idle_busy", busy_o, 0);
        check("idle_acks", ack_n, 0);

        send(8'h41, 0, a1);
        busy_len(n);
        check("busy_41", n, F);
        repeat (3) @(negedge clk_i);
        check("acks_41", ack_n, exp_acks);

        send(8'h0D, 0, a1);
        busy_len(n);
        check("busy_0d", n, F);
        repeat (5) @(negedge clk_i);

        send(8'h0D, 1, a1);
        send(8'h0A, 0, a2);
        check("b2b_gap", a2 - a1, F);
        busy_len(n);
        check("b2b_busy2", n, F);
        repeat (3) @(negedge clk_i);
        check("b2b_acks", ack_n, exp_acks);

        send(8'hFF, 0, a1);
        repeat (70) @(negedge clk_i);
        check("pre_rst_busy", busy_o, 1);
        #2 rstn_i = 1'b0;
        #1;
        check("async_txd", txd_o, 1);
        check("async_busy", busy_o, 0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (5) @(negedge clk_i);
        check("drop_acks", ack_n, exp_acks);
        send(8'h0A, 0, a1);
        busy_len(n);
        check("busy_after_rst", n, F);
        repeat (3) @(negedge clk_i);

        d2 = 8'h00;
        v2 = 1'b1;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (ack2 !== 1'b1 && n < 4 * F2);
        check("ack2_seen", ack2, 1);
        v2 = 1'b0;
        lo = 0;
        while (txd2 === 1'b0 && busy2 === 1'b1 && lo < 4 * F2) begin
            lo++;
            @(negedge clk_i);
        end
        hi = 0;
        while (txd2 === 1'b1 && busy2 === 1'b1 && hi < 4 * F2) begin
            hi++;
            @(negedge clk_i);
        end
        check("s2_low", lo, (9 + P) * CPB);
        check("s2_high", hi, 2 * CPB);
        check("s2_busy", lo + hi, F2);
        check("s2_idle", busy2, 0);

        repeat (5) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);
        check("total_acks", ack_n, exp_acks);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
